pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline-stage register. It is the next generation of the fixed four-word decode/execute register.
- It carries LANES words of WIDTH bits plus a one-bit side flag between two pipeline stages.
- Uses a valid/ready handshake and a two-entry skid buffer, so back-pressure never loses data and full throughput is kept.
- Provides a synchronous flush for branch/jump squash and a saturating stall counter for performance debug.

Parameters:
- WIDTH, 32, bits per lane.
- LANES, 4, number of lanes carried (e.g. PC, instruction, dataA, dataB).
- FLUSH_ZERO, 1, value 1 means flush also zeroes stored data and flag; value 0 means flush only clears valid.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash; has priority over everything except reset.
- in_valid  in  1  upstream has a word.
- in_ready  out  1  stage can accept. Combinational from state only, never from out_ready.
- in_data  in  LANES*WIDTH  lane 0 in bits [WIDTH-1:0].
- in_flag  in  1  side flag (e.g. jump marker).
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*WIDTH  registered output.
- out_flag  out  1  registered flag.
- stall_count  out  CNT_W  saturating stall count.

Behaviour:
- Handshake definitions:
  - Input fire = in_valid && in_ready.
  - Output fire = out_valid && out_ready.
- Storage:
  - Main register (M) drives out_data and out_flag directly.
  - Skid register (S) holds one extra word.
- States:
  - EMPTY: M invalid.
  - BUSY: M valid, S invalid.
  - FULL: M and S both valid.
- Outputs derived from state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL) && rst.
- Transitions, evaluated when flush = 0:
  - EMPTY, with input fire: M <= in, go to BUSY. Without input fire: stay EMPTY.
  - BUSY, input fire and output fire: M <= in, stay BUSY.
  - BUSY, input fire only: S <= in, go to FULL.
  - BUSY, output fire only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, output fire: M <= S, go to BUSY. No input fire is possible in FULL.
  - FULL, no output fire: hold.
- Latency and throughput:
  - 1 cycle from input fire in EMPTY to out_valid = 1.
  - Sustained throughput is 1 word/cycle while out_ready stays high.
  - Ordering is strictly FIFO.
- Output stability: while out_valid = 1 and out_ready = 0, out_data and out_flag must not change unless flush is asserted.
- Flush:
  - On the next edge, state goes to EMPTY; M and S are invalidated.
  - Any input fire in the flush cycle is discarded.
  - If FLUSH_ZERO = 1, M, S and the flag registers are cleared to 0. Otherwise their contents are left unchanged.
  - out_valid = 0 from the cycle after flush.
  - Flush while EMPTY has no effect beyond the zeroing.
- Stall counter:
  - stall_count increments on every cycle with out_valid = 1 and out_ready = 0.
  - Saturates at all-ones.
  - Cleared only by reset; flush does not clear it.
- Reset (rst = 0):
  - Takes effect immediately, asynchronously.
  - state = EMPTY, M = S = 0, flags = 0, out_valid = 0, stall_count = 0.
  - in_ready = 0 while rst is low; in_ready = 1 in the first cycle after release.
  - Reset asserted mid-transfer drops all held words.
- Width rule: data is passed through unmodified; no arithmetic is performed on it.

Test Plan:
- Reset then streaming:
  - Stimulus: release rst; in_valid = 1 with words 0x11..0x14 on lane 0 on consecutive cycles; out_ready = 1.
  - Required: out_valid rises 1 cycle after the first input fire; the same sequence appears on consecutive cycles; in_ready stays 1; stall_count = 0.
- Back-pressure:
  - Stimulus: stream A, B, C; drop out_ready to 0 while A is on the output.
  - Required: B is captured into S and the state becomes FULL; in_ready = 0; C is held upstream; out_data = A stays stable; stall_count increments by 1 per cycle.
  - Stimulus: raise out_ready.
  - Required: output order A, B, C.
- Flush while FULL with FLUSH_ZERO = 1:
  - Stimulus: fill to FULL, then pulse flush with in_valid = 1.
  - Required: next cycle out_valid = 0, out_data = 0, out_flag = 0, in_ready = 1; the word presented in the flush cycle never appears at the output.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges with the stage FULL.
  - Required: out_valid = 0, out_data = 0 and stall_count = 0 immediately, without waiting for a clock edge.
- Counter saturation:
  - Stimulus: CNT_W = 4; hold out_valid = 1 with out_ready = 0 for 20 cycles.
  - Required: stall_count = 0xF and stays there; a following flush leaves it at 0xF.
- Parameter sweep:
  - Stimulus: LANES = 1, WIDTH = 8 and LANES = 6, WIDTH = 64 with random valid/ready.
  - Required: the scoreboard shows no loss, no duplication and in-order delivery.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Handshaked pipeline-stage register with a two-entry skid buffer. It
//   carries LANES words of WIDTH bits plus a one-bit side flag from one
//   pipeline stage to the next. Back-pressure never drops a word, and one
//   word per cycle can pass while the downstream stage is ready.
//
//   The main register (M) drives the outputs directly. The skid register (S)
//   absorbs the one word that is accepted in the same cycle the downstream
//   stage stalls. in_ready depends only on the stored state, so there is no
//   combinational path from out_ready to in_ready.
//
// Parameters
//   WIDTH       bits per lane
//   LANES       number of lanes carried (lane 0 in in_data[WIDTH-1:0])
//   FLUSH_ZERO  1: flush also zeroes the stored data and flags
//               0: flush only clears valid
//   CNT_W       width of the saturating stall counter
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   flush        synchronous squash; overrides everything except reset
//   in_valid     upstream presents a word
//   in_ready     stage can accept a word (derived from state only)
//   in_data      LANES*WIDTH input word
//   in_flag      side flag travelling with the word
//   out_valid    output word is valid
//   out_ready    downstream accepts the output word
//   out_data     registered output word
//   out_flag     registered side flag
//   stall_count  cycles spent with out_valid=1 and out_ready=0 (saturating)

module pipe_stage_skid #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LANES      = 4,
  parameter bit          FLUSH_ZERO = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_flag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_flag,
  output logic [CNT_W-1:0]       stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [LANES*WIDTH-1:0] m_data;
  logic                   m_flag;
  logic [LANES*WIDTH-1:0] s_data;
  logic                   s_flag;

  logic in_fire;
  logic out_fire;
  logic load_m_in;
  logic load_m_s;
  logic load_s_in;

  // Qualifying in_ready with rst keeps the stage from advertising space
  // while it is being held in reset.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL) && rst;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_data  = m_data;
  assign out_flag  = m_flag;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and register-load decisions. Flush wins over every
  // handshake, so any word offered in a flush cycle is discarded.
  always_comb begin
    state_next = state;
    load_m_in  = 1'b0;
    load_m_s   = 1'b0;
    load_s_in  = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            load_m_in  = 1'b1;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_m_in  = 1'b1;
          end else if (in_fire) begin
            // Downstream stalled while a word was accepted: park it in S.
            load_s_in  = 1'b1;
            state_next = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain of S can happen.
          if (out_fire) begin
            load_m_s   = 1'b1;
            state_next = BUSY;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // Data and flag registers. M only changes on a load or a zeroing flush,
  // which keeps the output stable while the downstream stage stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data <= '0;
      m_flag <= 1'b0;
      s_data <= '0;
      s_flag <= 1'b0;
    end else if (flush) begin
      if (FLUSH_ZERO) begin
        m_data <= '0;
        m_flag <= 1'b0;
        s_data <= '0;
        s_flag <= 1'b0;
      end
    end else begin
      if (load_m_in) begin
        m_data <= in_data;
        m_flag <= in_flag;
      end else if (load_m_s) begin
        m_data <= s_data;
        m_flag <= s_flag;
      end
      if (load_s_in) begin
        s_data <= in_data;
        s_flag <= in_flag;
      end
    end
  end

  // Stall counter for performance debug. It survives flushes so that a
  // squash does not hide the stalls that came before it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
